// File: rtl/board_b_d_gfx_arbiter.sv
// Round-robin arbiter sharing one graphics-ROM read port between tile layers A and B.
// One memory transaction is in flight at a time, each supervised by an abort timeout.
module board_b_d_gfx_arbiter #(
  parameter int unsigned AW      = 20,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          CLK_32M,
  input  logic          RESET,
  input  logic          NL,
  input  logic          A_REQ,
  input  logic [AW-1:0] A_ADDR,
  output logic [DW-1:0] A_DATA,
  output logic          A_ACK,
  input  logic          B_REQ,
  input  logic [AW-1:0] B_ADDR,
  output logic [DW-1:0] B_DATA,
  output logic          B_ACK,
  output logic          MEM_REQ,
  output logic [AW-1:0] MEM_ADDR,
  input  logic          MEM_READY,
  input  logic [DW-1:0] MEM_DATA,
  input  logic          MEM_VALID,
  output logic          ERR
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 0: layer A, 1: layer B
  logic          prio_q, prio_d;    // 0: layer A wins a tie
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          err_q, err_d;

  logic any_req, grant_b, active, done, expire;

  always_comb begin
    any_req = A_REQ || B_REQ;
    grant_b = B_REQ && (!A_REQ || prio_q);
    active  = (state_q == StIssue) || (state_q == StWait);
    done    = (state_q == StWait) && MEM_VALID;
    // A completion landing on the expiry cycle takes precedence over the abort.
    expire  = active && (TIMEOUT != 0) && (cnt_q == CntLast) && !done;
  end

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: begin
        if (expire) begin
          state_d = StResp;
        end else if (MEM_READY) begin
          state_d = StWait;
        end
      end
      StWait:  if (done || expire) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    prio_d     = prio_q;
    cnt_d      = active ? cnt_q + CW'(1) : cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    err_d      = err_q;

    if (state_q == StIdle && any_req) begin
      owner_d    = grant_b;
      mem_req_d  = 1'b1;
      mem_addr_d = grant_b ? B_ADDR : A_ADDR;
      cnt_d      = '0;
    end

    if (state_q == StIssue && MEM_READY) begin
      mem_req_d = 1'b0;
    end

    if (done || expire) begin
      // An aborted fetch returns zero so the tile renders transparent.
      mem_req_d = 1'b0;
      if (owner_q) begin
        b_data_d = done ? MEM_DATA : '0;
        b_ack_d  = 1'b1;
      end else begin
        a_data_d = done ? MEM_DATA : '0;
        a_ack_d  = 1'b1;
      end
      if (expire) err_d = 1'b1;
      prio_d = ~owner_q;
    end

    if (NL) prio_d = 1'b0;
  end

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      err_q      <= err_d;
    end
  end

  assign MEM_REQ  = mem_req_q;
  assign MEM_ADDR = mem_addr_q;
  assign A_DATA   = a_data_q;
  assign A_ACK    = a_ack_q;
  assign B_DATA   = b_data_q;
  assign B_ACK    = b_ack_q;
  assign ERR      = err_q;

endmodule
